// File: rtl/nx_fifo_sched_pkg.sv
// Shared types for the nx_fifo read scheduler: FSM state, read tag, and the
// rotating-priority index helper.
package nx_fifo_sched_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Wide enough for any practical queue count; the top truncates to QW.
   localparam int TAG_QW = 8;

   typedef struct packed {
      logic              valid;
      logic [TAG_QW-1:0] qid;
   } tag_t;

   // Queue visited at search offset off (1..n) after base, wrapping modulo n.
   function automatic int rr_index(input int base, input int off, input int n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/nx_rr_pick.sv
// Rotating-priority picker: grants the first requester after 'last',
// wrapping modulo N so non-power-of-2 queue counts work.
module nx_rr_pick
   import nx_fifo_sched_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last,
   output logic [N-1:0] gnt,
   output logic [W-1:0] idx,
   output logic         found
);

   logic [W-1:0] cand;

   // 'last' itself is visited at offset N, so it wins only when alone.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 1; k <= N; k++) begin
         cand = W'(rr_index(int'(last), k, N));
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/nx_fifo_rd_sched.sv
// Weighted round-robin read scheduler for NUM_Q FIFO controllers sharing one
// RAM read port, with credit-gated pops and a qid tag aligned to read data.
module nx_fifo_rd_sched
   import nx_fifo_sched_pkg::*;
#(
   parameter int NUM_Q   = 4,
   parameter int BURST   = 4,
   parameter int CREDITS = 8,
   parameter int RD_LAT  = 2,
   localparam int QW = $clog2(NUM_Q),
   localparam int CW = $clog2(CREDITS + 1),
   localparam int BW = $clog2(BURST + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [NUM_Q-1:0] q_empty,
   output logic [NUM_Q-1:0] q_ren,
   output logic             rd_valid,
   output logic [QW-1:0]    rd_qid,
   input  logic             credit_return,
   output logic [CW-1:0]    credits,
   output logic             busy,
   output logic             cred_err
);

   state_t        state;
   logic [QW-1:0] cur_q;
   logic [QW-1:0] last_q;
   logic [BW-1:0] burst_cnt;
   logic [CW-1:0] credit_cnt;
   tag_t          pipe [RD_LAT];

   logic             issue_ok;
   logic             release_q;
   logic             pop_new;
   logic             pop_cur;
   logic             pop;
   logic [QW-1:0]    pop_qid;
   logic [QW-1:0]    pick_last;
   logic [NUM_Q-1:0] pick_gnt;
   logic [QW-1:0]    pick_idx;
   logic             pick_found;
   logic [NUM_Q-1:0] cur_onehot;
   logic             tags_live;

   assign issue_ok  = enable && (credit_cnt != '0);
   assign release_q = (state == GRANT) &&
                      ((burst_cnt == BW'(BURST)) || q_empty[cur_q]);
   // On release the outgoing queue becomes the lowest-priority requester.
   assign pick_last = (state == GRANT) ? cur_q : last_q;

   nx_rr_pick #(
      .N (NUM_Q),
      .W (QW)
   ) u_pick (
      .req   (~q_empty),
      .last  (pick_last),
      .gnt   (pick_gnt),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_comb begin
      cur_onehot        = '0;
      cur_onehot[cur_q] = 1'b1;
   end

   assign pop_new = issue_ok && pick_found && ((state == IDLE) || release_q);
   assign pop_cur = (state == GRANT) && !release_q && issue_ok;
   assign pop     = pop_new || pop_cur;
   assign pop_qid = pop_new ? pick_idx : cur_q;
   assign q_ren   = pop_new ? pick_gnt : (pop_cur ? cur_onehot : '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cur_q     <= '0;
         last_q    <= QW'(NUM_Q - 1);
         burst_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop_new) begin
                  cur_q     <= pick_idx;
                  burst_cnt <= BW'(1);
                  state     <= GRANT;
               end
            end
            GRANT: begin
               if (release_q) begin
                  last_q <= cur_q;
                  if (pop_new) begin
                     cur_q     <= pick_idx;
                     burst_cnt <= BW'(1);
                  end else begin
                     burst_cnt <= '0;
                     state     <= IDLE;
                  end
               end else if (pop_cur) begin
                  burst_cnt <= burst_cnt + BW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A pop and a return in the same cycle cancel; an over-return is flagged.
   always_ff @(posedge clk) begin
      if (rst) begin
         credit_cnt <= CW'(CREDITS);
         cred_err   <= 1'b0;
      end else begin
         if (credit_return && (credit_cnt == CW'(CREDITS)))
            cred_err <= 1'b1;
         if (pop && !credit_return)
            credit_cnt <= credit_cnt - CW'(1);
         else if (!pop && credit_return && (credit_cnt != CW'(CREDITS)))
            credit_cnt <= credit_cnt + CW'(1);
      end
   end

   // qid fields hold their last value so rd_qid is stable while rd_valid=0.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[0].valid <= pop;
         if (pop) pipe[0].qid <= TAG_QW'(pop_qid);
         for (int i = 1; i < RD_LAT; i++) begin
            pipe[i].valid <= pipe[i-1].valid;
            if (pipe[i-1].valid) pipe[i].qid <= pipe[i-1].qid;
         end
      end
   end

   always_comb begin
      tags_live = 1'b0;
      for (int i = 0; i < RD_LAT; i++) tags_live = tags_live | pipe[i].valid;
   end

   assign rd_valid = pipe[RD_LAT-1].valid;
   assign rd_qid   = pipe[RD_LAT-1].qid[QW-1:0];
   assign credits  = credit_cnt;
   assign busy     = (state != IDLE) || tags_live;

endmodule

// File: tb/tb_nx_fifo_rd_sched.sv
// Directed bench for nx_fifo_rd_sched with a per-queue occupancy model
// driving q_empty and hand-computed pop/tag/credit expectations.
module tb_nx_fifo_rd_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [3:0] q_empty;
   logic [3:0] q_ren;
   logic       rd_valid;
   logic [1:0] rd_qid;
   logic       credit_return;
   logic [3:0] credits;
   logic       busy;
   logic       cred_err;

   int cnt [4];
   int total = 0;
   int bad   = 0;
   int pops;

   logic [3:0] o_ren;
   logic       o_valid;
   logic [1:0] o_qid;
   logic [3:0] o_cred;
   logic       o_busy;
   logic       o_err;

   always #5 clk = ~clk;

   nx_fifo_rd_sched dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .q_empty       (q_empty),
      .q_ren         (q_ren),
      .rd_valid      (rd_valid),
      .rd_qid        (rd_qid),
      .credit_return (credit_return),
      .credits       (credits),
      .busy          (busy),
      .cred_err      (cred_err)
   );

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog expired");
   end

   task automatic upd_empty();
      for (int i = 0; i < 4; i++) q_empty[i] = (cnt[i] == 0);
   endtask

   task automatic set_cnt(input int c0, input int c1, input int c2, input int c3);
      cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3;
      upd_empty();
   endtask

   // One clock: sample outputs mid-cycle, then retire the observed pop in the queue model.
   task automatic step();
      @(negedge clk);
      o_ren   = q_ren;
      o_valid = rd_valid;
      o_qid   = rd_qid;
      o_cred  = credits;
      o_busy  = busy;
      o_err   = cred_err;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (o_ren[i] && cnt[i] != 0) cnt[i]--;
      upd_empty();
   endtask

   task automatic do_reset();
      enable = 1'b0;
      credit_return = 1'b0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      enable = 1'b0;
      credit_return = 1'b0;
      set_cnt(0, 0, 0, 0);

      // Reset values
      do_reset();
      rst = 1'b1;
      step();
      chk("rst_ren",    32'(o_ren),   32'h0);
      chk("rst_valid",  32'(o_valid), 32'h0);
      chk("rst_qid",    32'(o_qid),   32'h0);
      chk("rst_cred",   32'(o_cred),  32'd8);
      chk("rst_err",    32'(o_err),   32'h0);
      chk("rst_busy",   32'(o_busy),  32'h0);

      // 1: single entry in q0
      set_cnt(1, 0, 0, 0);
      do_reset();
      enable = 1'b1;
      step();
      chk("t1_ren0", 32'(o_ren), 32'h1);
      step();
      chk("t1_ren1",   32'(o_ren),   32'h0);
      chk("t1_valid1", 32'(o_valid), 32'h0);
      chk("t1_cred1",  32'(o_cred),  32'd7);
      step();
      chk("t1_valid2", 32'(o_valid), 32'h1);
      chk("t1_qid2",   32'(o_qid),   32'h0);

      // 2: all queues deep, bursts of 4 with no bubbles
      set_cnt(20, 20, 20, 20);
      do_reset();
      enable = 1'b1;
      for (int k = 0; k < 17; k++) begin
         step();
         credit_return = 1'b1;
         chk($sformatf("t2_ren%0d", k), 32'(o_ren), 32'(1 << ((k / 4) % 4)));
         if (k >= 2) begin
            chk($sformatf("t2_valid%0d", k), 32'(o_valid), 32'h1);
            chk($sformatf("t2_qid%0d", k),   32'(o_qid),   32'((k - 2) / 4 % 4));
         end
      end
      credit_return = 1'b0;
      chk("t2_cred", 32'(o_cred), 32'd7);

      // 3: credit exhaustion, then one returned credit allows one pop
      set_cnt(20, 20, 20, 20);
      do_reset();
      enable = 1'b1;
      pops = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (o_ren != 4'h0) pops++;
         if (k == 8) chk("t3_cred0", 32'(o_cred), 32'd0);
         if (k >= 8) chk($sformatf("t3_ren%0d", k), 32'(o_ren), 32'h0);
      end
      chk("t3_pops", 32'(pops), 32'd8);
      credit_return = 1'b1;
      step();
      chk("t3_ret_ren", 32'(o_ren), 32'h0);
      credit_return = 1'b0;
      step();
      chk("t3_cred1",  32'(o_cred), 32'd1);
      chk("t3_onepop", 32'(o_ren),  32'h4);
      step();
      chk("t3_cred_after", 32'(o_cred), 32'd0);
      chk("t3_ren_after",  32'(o_ren),  32'h0);

      // 4: q1 holds two entries
      set_cnt(0, 2, 0, 0);
      do_reset();
      enable = 1'b1;
      step(); chk("t4_ren0", 32'(o_ren), 32'h2);
      step(); chk("t4_ren1", 32'(o_ren), 32'h2);
      step();
      chk("t4_ren2",   32'(o_ren),   32'h0);
      chk("t4_valid2", 32'(o_valid), 32'h1);
      chk("t4_qid2",   32'(o_qid),   32'h1);
      step();
      chk("t4_ren3",   32'(o_ren),   32'h0);
      chk("t4_valid3", 32'(o_valid), 32'h1);
      chk("t4_qid3",   32'(o_qid),   32'h1);
      chk("t4_busy3",  32'(o_busy),  32'h1);
      step();
      chk("t4_valid4", 32'(o_valid), 32'h0);
      chk("t4_qidhold", 32'(o_qid),  32'h1);
      chk("t4_busy4",  32'(o_busy),  32'h0);

      // 5: enable drops mid-burst on q2, burst resumes, then rotates to q3
      set_cnt(0, 0, 10, 10);
      do_reset();
      enable = 1'b1;
      step(); chk("t5_ren0", 32'(o_ren), 32'h4);
      step(); chk("t5_ren1", 32'(o_ren), 32'h4);
      enable = 1'b0;
      step();
      chk("t5_ren2",   32'(o_ren),   32'h0);
      chk("t5_valid2", 32'(o_valid), 32'h1);
      chk("t5_qid2",   32'(o_qid),   32'h2);
      step();
      chk("t5_ren3",   32'(o_ren),   32'h0);
      chk("t5_valid3", 32'(o_valid), 32'h1);
      step();
      chk("t5_ren4",   32'(o_ren),   32'h0);
      chk("t5_valid4", 32'(o_valid), 32'h0);
      enable = 1'b1;
      step(); chk("t5_ren5", 32'(o_ren), 32'h4);
      step(); chk("t5_ren6", 32'(o_ren), 32'h4);
      step(); chk("t5_ren7", 32'(o_ren), 32'h8);
      step();
      chk("t5_cred", 32'(o_cred), 32'd3);
      chk("t5_ren8", 32'(o_ren),  32'h8);

      // 6: over-return sets sticky cred_err; reset mid-burst clears everything
      set_cnt(0, 20, 20, 0);
      do_reset();
      credit_return = 1'b1;
      step();
      chk("t6_err0",  32'(o_err),  32'h0);
      credit_return = 1'b0;
      step();
      chk("t6_err1",  32'(o_err),  32'h1);
      chk("t6_cred1", 32'(o_cred), 32'd8);
      enable = 1'b1;
      step(); chk("t6_ren_a", 32'(o_ren), 32'h2);
      step(); chk("t6_ren_b", 32'(o_ren), 32'h2);
      chk("t6_err_sticky", 32'(o_err), 32'h1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      enable = 1'b0;
      step();
      chk("t6_rst_ren",   32'(o_ren),   32'h0);
      chk("t6_rst_valid", 32'(o_valid), 32'h0);
      chk("t6_rst_qid",   32'(o_qid),   32'h0);
      chk("t6_rst_cred",  32'(o_cred),  32'd8);
      chk("t6_rst_err",   32'(o_err),   32'h0);
      chk("t6_rst_busy",  32'(o_busy),  32'h0);
      enable = 1'b1;
      step();
      chk("t6_restart", 32'(o_ren), 32'h2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
